// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, PC constants and buffer entry type for the fetch stage.
// Revision 1.0
`default_nettype none

package if_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0]       pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous instruction buffer with push/pop/flush, count and head outputs.
// Revision 1.0
`default_nettype none

module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output fetch_entry_t       o_head
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t            r_mem [DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    w_do_pop;
  logic                    w_do_push;

  // A pop in the same cycle frees the slot a full-buffer push needs.
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count < CNT_W'(DEPTH)) | w_do_pop);

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// if_fetch: fetch PC, credit-limited imem req/gnt/rvalid interface, redirect kill tracking.
// Revision 1.0
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [XLEN-1:0]       imem_rdata,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [XLEN-1:0]       inst_pc
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    r_resp_pc;
  logic [c_CNT_W-1:0] r_out_cnt;
  logic [c_CNT_W-1:0] r_kill_cnt;

  logic [c_CNT_W-1:0] w_fifo_count;
  logic [c_CNT_W:0]   w_pending;
  logic [c_CNT_W:0]   w_kill_redir;
  logic [c_CNT_W+1:0] w_used;
  logic               w_gnt_hs;
  logic               w_rsp;
  logic               w_rsp_keep;
  fetch_entry_t       w_push_data;
  fetch_entry_t       w_head;

  assign w_pending = {1'b0, r_out_cnt} + {1'b0, r_kill_cnt};
  assign w_used    = {2'b00, w_fifo_count} + {1'b0, w_pending};

  // Killed words still occupy credit until they come back.
  assign imem_req  = rst & ~redirect & (w_used < (c_CNT_W + 2)'(FIFO_DEPTH));
  assign imem_addr = r_fetch_pc;

  assign w_gnt_hs     = imem_req & imem_gnt;
  assign w_rsp        = imem_rvalid & (w_pending != '0);
  assign w_rsp_keep   = w_rsp & (r_kill_cnt == '0);
  assign w_kill_redir = w_pending - (c_CNT_W + 1)'(w_rsp);
  assign w_push_data  = '{inst: imem_rdata, pc: r_resp_pc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_kill_cnt <= '0;
    end else if (redirect) begin
      r_fetch_pc <= word_align(redirect_pc);
      r_resp_pc  <= word_align(redirect_pc);
      r_out_cnt  <= '0;
      r_kill_cnt <= w_kill_redir[c_CNT_W-1:0];
    end else begin
      if (w_gnt_hs)   r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_rsp_keep) r_resp_pc  <= r_resp_pc + PC_STEP;
      if (w_rsp && r_kill_cnt != '0) r_kill_cnt <= r_kill_cnt - c_CNT_W'(1);
      unique case ({w_gnt_hs, w_rsp_keep})
        2'b10:   r_out_cnt <= r_out_cnt + c_CNT_W'(1);
        2'b01:   r_out_cnt <= r_out_cnt - c_CNT_W'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (c_CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_rsp_keep & ~redirect),
    .i_data  (w_push_data),
    .i_pop   (inst_valid & inst_ready & ~redirect),
    .i_flush (redirect),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  assign inst_valid  = (w_fifo_count != '0);
  assign instruction = inst_valid ? w_head.inst : '0;
  assign inst_pc     = inst_valid ? w_head.pc   : '0;

`ifndef SYNTHESIS
  a_rvalid_needs_pending: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (w_pending != '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// tb_if_fetch: per-cycle vector table, reset corner sequence and a randomized memory model.
// Revision 1.0
`default_nettype none

module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int total;
  int bad;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic g, input logic rv, input logic [31:0] rd, input logic rdr,
                     input logic [31:0] rpc, input logic rdy, input logic ereq,
                     input logic [31:0] eaddr, input logic eval, input logic [31:0] einst,
                     input logic [31:0] epc);
    vec_t v;
    v = '{gnt: g, rv: rv, rdata: rd, redir: rdr, rpc: rpc, rdy: rdy, e_req: ereq,
          e_addr: eaddr, e_val: eval, e_inst: einst, e_pc: epc};
    vecs.push_back(v);
  endtask

  function automatic logic [97:0] outs();
    return {imem_req, imem_addr, inst_valid, instruction, inst_pc};
  endfunction

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic rdr,
                       input logic [31:0] rpc, input logic rdy);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    inst_ready  = rdy;
  endtask

  initial begin
    int unsigned q_addr[$];
    int          q_due[$];
    int          last_due;
    int          d;
    int          pops;
    logic [31:0] exp_pc;

    total = 0;
    bad   = 0;

    //   gnt rv rdata          rdr rpc            rdy | req addr         val inst           pc
    add(1, 0, 32'h0,          0, 32'h0,        0,    1, 32'h0,        0, 32'h0,        32'h0);
    add(1, 1, 32'h00500093,   0, 32'h0,        0,    1, 32'h4,        0, 32'h0,        32'h0);
    add(1, 1, 32'h00600113,   0, 32'h0,        0,    0, 32'h8,        1, 32'h00500093, 32'h0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 32'h0,        0, 32'h0,        0,    0, 32'h8,        1, 32'h00500093, 32'h0);
    add(1, 0, 32'h0,          0, 32'h0,        1,    0, 32'h8,        1, 32'h00500093, 32'h0);
    add(1, 0, 32'h0,          0, 32'h0,        1,    1, 32'h8,        1, 32'h00600113, 32'h4);
    add(1, 1, 32'h00700193,   0, 32'h0,        1,    1, 32'hC,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,          0, 32'h0,        1,    0, 32'h10,       1, 32'h00700193, 32'h8);
    // grant withheld: request and address must hold
    for (int i = 0; i < 4; i++)
      add(0, 0, 32'h0,        0, 32'h0,        0,    1, 32'h10,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,          0, 32'h0,        0,    1, 32'h10,       0, 32'h0,        32'h0);
    // redirect with 0xC and 0x10 in flight
    add(1, 0, 32'h0,          1, 32'h103,      1,    0, 32'h14,       0, 32'h0,        32'h0);
    add(1, 1, 32'hDEAD0001,   0, 32'h0,        0,    0, 32'h100,      0, 32'h0,        32'h0);
    add(1, 1, 32'hDEAD0002,   0, 32'h0,        0,    1, 32'h100,      0, 32'h0,        32'h0);
    add(0, 1, 32'h00A00513,   0, 32'h0,        0,    1, 32'h104,      0, 32'h0,        32'h0);
    add(1, 0, 32'h0,          0, 32'h0,        0,    1, 32'h104,      1, 32'h00A00513, 32'h100);
    // redirect coincides with rvalid and pop
    add(1, 1, 32'h11111111,   1, 32'h200,      1,    0, 32'h108,      1, 32'h00A00513, 32'h100);
    add(0, 0, 32'h0,          0, 32'h0,        1,    1, 32'h200,      0, 32'h0,        32'h0);
    add(1, 0, 32'h0,          0, 32'h0,        0,    1, 32'h200,      0, 32'h0,        32'h0);
    add(0, 1, 32'h22222222,   0, 32'h0,        0,    1, 32'h204,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,          0, 32'h0,        0,    1, 32'h204,      1, 32'h22222222, 32'h200);
    // address wrap
    add(0, 0, 32'h0,          1, 32'hFFFFFFFF, 1,    0, 32'h204,      1, 32'h22222222, 32'h200);
    add(1, 0, 32'h0,          0, 32'h0,        0,    1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    add(1, 1, 32'h33333333,   0, 32'h0,        0,    1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'h44444444,   0, 32'h0,        1,    0, 32'h4,        1, 32'h33333333, 32'hFFFFFFFC);
    add(0, 0, 32'h0,          0, 32'h0,        0,    1, 32'h4,        1, 32'h44444444, 32'h0);

    rst = 1'b0;
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk);
    #1;
    chk("reset_outputs", 128'(outs()), 128'({1'b0, 32'h0, 1'b0, 32'h0, 32'h0}));

    foreach (vecs[i]) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      #1;
      chk($sformatf("row%0d", i), 128'(outs()),
          128'({vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val, vecs[i].e_inst, vecs[i].e_pc}));
    end

    // Fill the buffer, then assert reset mid-cycle.
    @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk); drive(0, 1, 32'h55555555, 0, 32'h0, 0);
    @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0, 0);
    #1;
    chk("full_before_rst", 128'(outs()), 128'({1'b0, 32'h8, 1'b1, 32'h44444444, 32'h0}));
    #1 rst = 1'b0;
    #1;
    chk("async_rst_outputs", 128'(outs()), 128'({1'b0, 32'h0, 1'b0, 32'h0, 32'h0}));
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    rst = 1'b1;
    #1;
    chk("restart_pc", 128'(outs()), 128'({1'b1, 32'h0, 1'b0, 32'h0, 32'h0}));

    // Randomized latency / redirect stream against a reference PC model.
    last_due = 0;
    pops     = 0;
    exp_pc   = 32'h0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      imem_gnt    = ($urandom_range(0, 3) != 0);
      inst_ready  = ($urandom_range(0, 2) != 0);
      if (q_addr.size() > 0 && q_due[0] <= cyc && $urandom_range(0, 3) != 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memval(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      #1;
      if (imem_req && imem_gnt) begin
        d = cyc + int'($urandom_range(1, 6));
        if (d < last_due) d = last_due;
        last_due = d;
        q_addr.push_back(imem_addr);
        q_due.push_back(d);
      end
      if (inst_valid && inst_ready && !redirect) begin
        chk("stream", 128'({inst_pc, instruction}), 128'({exp_pc, memval(exp_pc)}));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    chk("stream_progress", 128'(pops >= 800), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
